irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Parametrised interrupt controller on the CPU bus. Generalises the current single-source, keyboard-only vector/ack logic to NUM_SRC sources.
- Per-source edge capture, pending and enable registers, fixed-priority arbitration.
- Drives the riscv64 `interrupt_vector`/`interrupt_ack` handshake.
- Register window is memory-mapped on the 64-bit bus, next to the Key/Art devices.

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..15); source i reports vector i+1.
- VEC_W, 4, vector width; 2^VEC_W-1 >= NUM_SRC required.
- BASE_ADDR, 64'h0000_0000_0000_2100, register window base (16-byte aligned).

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset_n  in  1  synchronous active-low reset
- irq_src  in  NUM_SRC  raw source lines, already synchronous to clk
- interrupt_vector  out  VEC_W  presented vector; 0 = none
- interrupt_ack  in  1  CPU acknowledge of presented vector
- bus_address  in  64  byte address
- bus_write_enable  in  1  write strobe
- bus_read_enable  in  1  read strobe
- bus_write_data  in  64  write data; bits [NUM_SRC-1:0] used
- bus_read_data  out  64  registered read data
- irq_pending_any  out  1  OR of (pending & enable), for debug LED

Behaviour:
- Reset: only on a clk edge with reset_n=0. All outputs 0; pending=0; enable=0; src_dly=0; FSM=IDLE. Reset mid-handshake drops the vector the same edge.
- Edge capture: rise[i] = irq_src[i] & ~src_dly[i]. src_dly registered every cycle. A rising edge sets pending[i] regardless of enable.
- Select: sel = bus_address[63:4]==BASE_ADDR[63:4]. Register offset = bus_address[3:2].
  - 0: PENDING. Read. Write-1-to-clear.
  - 1: ENABLE. Read/write.
  - 2: CLAIM. Read-only; returns the current vector zero-extended.
  - 3: reads 0; writes ignored.
- Read latency: bus_read_data updates one cycle after sel & bus_read_enable. It holds its value otherwise. Upper bits above NUM_SRC/VEC_W read 0.
- Set priority: set beats clear. A rising edge in the same cycle as a W1C or ack-clear leaves the pending bit 1.
- Arbitration: cand = pending & enable. Winner = lowest index set. Vector = index+1.
- FSM states:
  - IDLE: vector=0. If cand!=0, latch the winner into the vector at the next edge → PRESENT.
  - PRESENT: vector held stable, and not preempted by a higher-priority arrival.
    - If interrupt_ack=1: clear pending[vector-1] → GAP.
    - Else if enable[vector-1] or pending[vector-1] goes 0 (bus write): vector←0 → IDLE.
  - GAP: vector=0 for exactly one cycle → IDLE. This guarantees the CPU sees a deassertion between interrupts.
- interrupt_ack in IDLE/GAP is ignored.
- ack held high across several cycles clears only one source. The GAP + IDLE path gives at least 2 cycles before the next vector.
- irq_pending_any is combinational from registers: |cand.

Optional Feature:
- Macro: IRQ_CONTROLLER_LEVEL_EN.
- With the macro:
  - Offset 3 becomes MODE (read/write, reset 0). MODE[i]=1 makes source i level-sensitive: pending[i] = irq_src[i] each cycle.
  - W1C and ack have no effect on level sources. The presentation is withdrawn via the PRESENT→IDLE path when the line drops.
- Without the macro: all sources edge-triggered; offset 3 reads 0.

Test Plan:
1. Reset, ENABLE←0x1, pulse irq_src[0] for 1 cycle → interrupt_vector=1 two cycles later. Ack 1 cycle → vector 0 next cycle; PENDING reads 0x0.
2. ENABLE←0xF, rise src[2] and src[1] same cycle → vector=2. After ack + GAP → vector=3. After ack → 0; PENDING=0.
3. Vector 3 presented, src[0] rises → vector stays 3 until ack, then 1 after GAP.
4. Src[1] pending, ENABLE=0 → vector 0, irq_pending_any=0, PENDING=0x2. ENABLE←0x2 → vector 2. Write PENDING←0x2 without ack → vector 0, FSM IDLE.
5. Ack cycle coincides with new rise of the same source (src[0]) → pending[0] stays 1, vector 1 reappears after GAP. Read CLAIM in GAP → 0.
6. reset_n=0 for one edge while vector=2 → vector 0, ENABLE=0, PENDING=0. IRQ_CONTROLLER_LEVEL_EN build: MODE←0x1, hold src[0] high → vector 1. Ack → GAP → vector 1 again. Drop src[0] → vector 0.

Source files
------------

// File: rtl/irq_controller.sv
// irq_controller: NUM_SRC-source interrupt controller with fixed priority and a vector/ack handshake.
// Define IRQ_CONTROLLER_LEVEL_EN to add the per-source level-sensitive MODE register at offset 3.
module irq_controller #(
  parameter int          NUM_SRC   = 4,
  parameter int          VEC_W     = 4,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0000_2100
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic [VEC_W-1:0]   interrupt_vector,
  input  logic               interrupt_ack,
  input  logic [63:0]        bus_address,
  input  logic               bus_write_enable,
  input  logic               bus_read_enable,
  input  logic [63:0]        bus_write_data,
  output logic [63:0]        bus_read_data,
  output logic               irq_pending_any
);
  typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;
  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] src_dly_q, pending_q, pending_d, enable_q, enable_d, mode_q;
  logic [NUM_SRC-1:0] rise, cand, vec_oh, clr;
  logic [VEC_W-1:0]   vec_q, vec_d, win;
  logic [63:0]        rdata_q, rdata_d;
  logic               sel, wr, rd;
  logic [1:0]         off;
  logic               unused_bits;
`ifdef IRQ_CONTROLLER_LEVEL_EN
  logic [NUM_SRC-1:0] mode_d;
  always_ff @(posedge clk) mode_q <= !reset_n ? '0 : mode_d;
  always_comb mode_d = (wr && off == 2'd3) ? bus_write_data[NUM_SRC-1:0] : mode_q;
`else
  assign mode_q = '0;
`endif
  assign unused_bits = ^{bus_write_data[63:NUM_SRC], bus_address[1:0]};
  always_comb begin
    rise    = irq_src & ~src_dly_q;
    cand    = pending_q & enable_q;
    sel     = bus_address[63:4] == BASE_ADDR[63:4];
    wr      = sel & bus_write_enable;
    rd      = sel & bus_read_enable;
    off     = bus_address[3:2];
    win     = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (cand[i]) win = VEC_W'(i + 1);
    for (int i = 0; i < NUM_SRC; i++) vec_oh[i] = vec_q == VEC_W'(i + 1);
    clr     = ((wr && off == 2'd0) ? bus_write_data[NUM_SRC-1:0] : '0) |
              ((state_q == PRESENT && interrupt_ack) ? vec_oh : '0);
    // a rising edge wins over any clear landing in the same cycle; level sources just follow the line
    pending_d = (mode_q & irq_src) | (~mode_q & ((pending_q & ~clr) | rise));
    enable_d  = (wr && off == 2'd1) ? bus_write_data[NUM_SRC-1:0] : enable_q;
    rdata_d   = !rd ? rdata_q :
                off == 2'd0 ? 64'(pending_q) :
                off == 2'd1 ? 64'(enable_q) :
                off == 2'd2 ? 64'(vec_q) : 64'(mode_q);
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE:    if (cand != '0) begin
                 state_d = PRESENT;
                 vec_d   = win;
               end
      PRESENT: if (interrupt_ack) begin
                 state_d = GAP;
                 vec_d   = '0;
               end else if (~|(cand & vec_oh)) begin
                 state_d = IDLE;
                 vec_d   = '0;
               end
      default: begin
                 state_d = IDLE;
                 vec_d   = '0;
               end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      src_dly_q <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      src_dly_q <= irq_src;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      rdata_q   <= rdata_d;
    end
  end
  assign interrupt_vector = vec_q;
  assign bus_read_data    = rdata_q;
  assign irq_pending_any  = |cand;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed scenarios plus randomized traffic against a cycle-level behavioural model.
module tb_irq_controller;
  localparam int NS = 4;
  localparam int VW = 4;
  localparam logic [63:0] BASE = 64'h0000_0000_0000_2100;
`ifdef IRQ_CONTROLLER_LEVEL_EN
  localparam bit LVL = 1'b1;
`else
  localparam bit LVL = 1'b0;
`endif
  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [NS-1:0] irq_src = '0;
  logic [VW-1:0] interrupt_vector;
  logic          interrupt_ack = 1'b0;
  logic [63:0]   bus_address = BASE;
  logic          bus_write_enable = 1'b0;
  logic          bus_read_enable = 1'b0;
  logic [63:0]   bus_write_data = '0;
  logic [63:0]   bus_read_data;
  logic          irq_pending_any;
  int            n_chk = 0;
  int            n_fail = 0;
  logic [NS-1:0] m_pend, m_en, m_prev, m_mode;
  int            m_vec;
  bit            m_gap;
  logic [63:0]   m_rd;

  irq_controller #(.NUM_SRC(NS), .VEC_W(VW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .irq_src(irq_src), .interrupt_vector(interrupt_vector),
    .interrupt_ack(interrupt_ack), .bus_address(bus_address), .bus_write_enable(bus_write_enable),
    .bus_read_enable(bus_read_enable), .bus_write_data(bus_write_data),
    .bus_read_data(bus_read_data), .irq_pending_any(irq_pending_any)
  );

  always #5 clk = ~clk;

  // One clock edge of the controller described by its rules, using the values held before the edge.
  task automatic model_step();
    logic [NS-1:0] rise, cand, clr;
    bit sel;
    int off;
    if (!reset_n) begin
      m_pend = '0; m_en = '0; m_prev = '0; m_mode = '0; m_vec = 0; m_gap = 0; m_rd = '0;
      return;
    end
    sel  = (bus_address >> 4) == (BASE >> 4);
    off  = int'(bus_address[3:2]);
    cand = m_pend & m_en;
    clr  = '0;
    if (sel && bus_read_enable)
      m_rd = off == 0 ? 64'(m_pend) : off == 1 ? 64'(m_en) : off == 2 ? 64'(m_vec) :
             (LVL ? 64'(m_mode) : 64'd0);
    if (m_gap) m_gap = 0;
    else if (m_vec == 0) begin
      for (int i = 0; i < NS; i++) if (cand[i]) begin m_vec = i + 1; break; end
    end else if (interrupt_ack) begin
      clr[m_vec-1] = 1'b1;
      m_vec = 0;
      m_gap = 1;
    end else if (!cand[m_vec-1]) m_vec = 0;
    if (sel && bus_write_enable && off == 0) clr |= bus_write_data[NS-1:0];
    rise = irq_src & ~m_prev;
    for (int i = 0; i < NS; i++)
      m_pend[i] = m_mode[i] ? irq_src[i] : (rise[i] | (m_pend[i] & ~clr[i]));
    if (sel && bus_write_enable && off == 1) m_en = bus_write_data[NS-1:0];
    if (LVL && sel && bus_write_enable && off == 3) m_mode = bus_write_data[NS-1:0];
    m_prev = irq_src;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic bus_write(input int off, input logic [63:0] d);
    bus_address = BASE + (64'(off) << 2);
    bus_write_data = d;
    bus_write_enable = 1'b1;
    tick();
    bus_write_enable = 1'b0;
  endtask

  task automatic bus_read(input int off, output logic [63:0] d);
    bus_address = BASE + (64'(off) << 2);
    bus_read_enable = 1'b1;
    tick();
    bus_read_enable = 1'b0;
    d = bus_read_data;
  endtask

  task automatic test_reset();
    logic [63:0] d;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_chk++; if (interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL reset_vector got %0d want 0", interrupt_vector); end
    n_chk++; if (irq_pending_any !== 1'b0) begin n_fail++; $display("FAIL reset_any got %0b want 0", irq_pending_any); end
    n_chk++; if (bus_read_data !== 64'd0) begin n_fail++; $display("FAIL reset_rdata got %0h want 0", bus_read_data); end
    bus_read(1, d);
    n_chk++; if (d !== 64'd0) begin n_fail++; $display("FAIL reset_enable got %0h want 0", d); end
  endtask

  task automatic test_basic();
    logic [63:0] d;
    bus_write(1, 64'h1);
    irq_src = 4'b0001;
    tick();
    irq_src = '0;
    n_chk++; if (interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL basic_early got %0d want 0", interrupt_vector); end
    tick();
    n_chk++; if (interrupt_vector !== 4'd1) begin n_fail++; $display("FAIL basic_vector got %0d want 1", interrupt_vector); end
    n_chk++; if (irq_pending_any !== 1'b1) begin n_fail++; $display("FAIL basic_any got %0b want 1", irq_pending_any); end
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    n_chk++; if (interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL basic_ack got %0d want 0", interrupt_vector); end
    bus_read(0, d);
    n_chk++; if (d !== 64'd0) begin n_fail++; $display("FAIL basic_pending got %0h want 0", d); end
  endtask

  task automatic test_priority();
    logic [63:0] d;
    bus_write(1, 64'hF);
    irq_src = 4'b0110;
    tick();
    irq_src = '0;
    tick();
    n_chk++; if (interrupt_vector !== 4'd2) begin n_fail++; $display("FAIL prio_first got %0d want 2", interrupt_vector); end
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    n_chk++; if (interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL prio_gap got %0d want 0", interrupt_vector); end
    tick();
    n_chk++; if (interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL prio_idle got %0d want 0", interrupt_vector); end
    tick();
    n_chk++; if (interrupt_vector !== 4'd3) begin n_fail++; $display("FAIL prio_second got %0d want 3", interrupt_vector); end
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    bus_read(0, d);
    n_chk++; if (d !== 64'd0) begin n_fail++; $display("FAIL prio_pending got %0h want 0", d); end
    n_chk++; if (interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL prio_end got %0d want 0", interrupt_vector); end
  endtask

  task automatic test_no_preempt();
    irq_src = 4'b0100;
    tick();
    irq_src = '0;
    tick();
    irq_src = 4'b0001;
    tick();
    irq_src = '0;
    tick();
    tick();
    n_chk++; if (interrupt_vector !== 4'd3) begin n_fail++; $display("FAIL nopreempt_hold got %0d want 3", interrupt_vector); end
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    tick();
    tick();
    n_chk++; if (interrupt_vector !== 4'd1) begin n_fail++; $display("FAIL nopreempt_next got %0d want 1", interrupt_vector); end
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
  endtask

  task automatic test_enable_gate();
    logic [63:0] d;
    bus_write(1, 64'h0);
    irq_src = 4'b0010;
    tick();
    irq_src = '0;
    tick();
    tick();
    n_chk++; if (interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL gate_vector got %0d want 0", interrupt_vector); end
    n_chk++; if (irq_pending_any !== 1'b0) begin n_fail++; $display("FAIL gate_any got %0b want 0", irq_pending_any); end
    bus_read(0, d);
    n_chk++; if (d !== 64'h2) begin n_fail++; $display("FAIL gate_pending got %0h want 2", d); end
    bus_write(1, 64'h2);
    tick();
    n_chk++; if (interrupt_vector !== 4'd2) begin n_fail++; $display("FAIL gate_enabled got %0d want 2", interrupt_vector); end
    bus_write(0, 64'h2);
    tick();
    tick();
    n_chk++; if (interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL gate_w1c_withdraw got %0d want 0", interrupt_vector); end
    n_chk++; if (irq_pending_any !== 1'b0) begin n_fail++; $display("FAIL gate_w1c_any got %0b want 0", irq_pending_any); end
  endtask

  task automatic test_ack_rise();
    logic [63:0] d;
    bus_write(1, 64'hF);
    irq_src = 4'b0001;
    tick();
    irq_src = '0;
    tick();
    n_chk++; if (interrupt_vector !== 4'd1) begin n_fail++; $display("FAIL ackrise_first got %0d want 1", interrupt_vector); end
    irq_src = 4'b0001;
    interrupt_ack = 1'b1;
    tick();
    irq_src = '0;
    interrupt_ack = 1'b0;
    bus_read(2, d);
    n_chk++; if (d !== 64'd0) begin n_fail++; $display("FAIL ackrise_claim_gap got %0h want 0", d); end
    tick();
    n_chk++; if (interrupt_vector !== 4'd1) begin n_fail++; $display("FAIL ackrise_again got %0d want 1", interrupt_vector); end
    bus_read(2, d);
    n_chk++; if (d !== 64'd1) begin n_fail++; $display("FAIL ackrise_claim got %0h want 1", d); end
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    irq_src = 4'b0010;
    tick();
    irq_src = '0;
    tick();
    n_chk++; if (interrupt_vector !== 4'd2) begin n_fail++; $display("FAIL rstmid_pre got %0d want 2", interrupt_vector); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_chk++; if (interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL rstmid_vector got %0d want 0", interrupt_vector); end
    bus_read(1, d);
    n_chk++; if (d !== 64'd0) begin n_fail++; $display("FAIL rstmid_enable got %0h want 0", d); end
    bus_read(0, d);
    n_chk++; if (d !== 64'd0) begin n_fail++; $display("FAIL rstmid_pending got %0h want 0", d); end
  endtask

`ifdef IRQ_CONTROLLER_LEVEL_EN
  task automatic test_level();
    logic [63:0] d;
    bus_write(1, 64'h1);
    bus_write(3, 64'h1);
    irq_src = 4'b0001;
    tick();
    tick();
    n_chk++; if (interrupt_vector !== 4'd1) begin n_fail++; $display("FAIL level_first got %0d want 1", interrupt_vector); end
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    tick();
    tick();
    n_chk++; if (interrupt_vector !== 4'd1) begin n_fail++; $display("FAIL level_again got %0d want 1", interrupt_vector); end
    irq_src = '0;
    tick();
    tick();
    n_chk++; if (interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL level_drop got %0d want 0", interrupt_vector); end
    bus_read(3, d);
    n_chk++; if (d !== 64'h1) begin n_fail++; $display("FAIL level_mode got %0h want 1", d); end
  endtask
`endif

  task automatic test_random();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      reset_n          = $urandom_range(0, 99) != 0;
      irq_src          = NS'($urandom);
      interrupt_ack    = $urandom_range(0, 9) < 4;
      bus_write_enable = $urandom_range(0, 9) < 2;
      bus_read_enable  = $urandom_range(0, 9) < 4;
      bus_write_data   = {$urandom, $urandom};
      bus_address      = $urandom_range(0, 3) == 0 ? BASE + 64'(16 * $urandom_range(1, 4))
                                                   : BASE + 64'($urandom_range(0, 15));
      tick();
      n_chk++; if (interrupt_vector !== VW'(m_vec)) begin n_fail++; $display("FAIL rand_vector cyc %0d got %0d want %0d", c, interrupt_vector, m_vec); end
      n_chk++; if (irq_pending_any !== |(m_pend & m_en)) begin n_fail++; $display("FAIL rand_any cyc %0d got %0b want %0b", c, irq_pending_any, |(m_pend & m_en)); end
      n_chk++; if (bus_read_data !== m_rd) begin n_fail++; $display("FAIL rand_rdata cyc %0d got %0h want %0h", c, bus_read_data, m_rd); end
    end
    reset_n = 1'b1;
    interrupt_ack = 1'b0;
    bus_write_enable = 1'b0;
    bus_read_enable = 1'b0;
    irq_src = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_no_preempt();
    test_enable_gate();
    test_ack_rise();
    test_reset_mid();
`ifdef IRQ_CONTROLLER_LEVEL_EN
    test_level();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
